// File: rtl/mem_cache_nway_ctrl.sv
// N-way set-associative write-through data cache with true-LRU replacement and flush.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module mem_cache_nway_ctrl #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int ADDR_W = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_bus_in,
  input  logic [31:0] write_data_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        flush_in,
  output logic [31:0] read_data_out,
  output logic        ready_out,
  input  logic [63:0] sram_read_data_in,
  input  logic        sram_ready_in,
  output logic [31:0] sram_addr_out,
  output logic [31:0] sram_write_data_out,
  output logic        sram_r_en_out,
  output logic        sram_w_en_out
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out
`endif
);
  localparam int WW = $clog2(WAYS);
  localparam int SW = $clog2(SETS);
  localparam int TW = ADDR_W - SW - 1;

  typedef enum logic [1:0] {S_IDLE, S_RFILL, S_WRITE} state_t;

  state_t        state_reg;
  logic          sram_r_en_reg, sram_w_en_reg, flush_pend_reg;
  logic          valid_reg [SETS][WAYS];
  logic [WW-1:0] age_reg   [SETS][WAYS];
  logic [TW-1:0] tag_reg   [SETS][WAYS];
  logic [31:0]   data_reg  [SETS][WAYS][2];

  logic [SW-1:0] idx;
  logic [TW-1:0] tag;
  logic          word_sel;
  logic [31:0]   addr_full;
  assign idx       = address_bus_in[SW:1];
  assign tag       = address_bus_in[ADDR_W-1:SW+1];
  assign word_sel  = address_bus_in[0];
  assign addr_full = 32'(address_bus_in[ADDR_W-1:0]);

  if (ADDR_W < 32) begin : g_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_bus_in[31:ADDR_W];
  end

  // A pending or same-cycle flush wins over the lookup in S_IDLE.
  logic flush_eff;
  assign flush_eff = (state_reg == S_IDLE) && (flush_in || flush_pend_reg);

  logic [WAYS-1:0] hit_vec;
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_cmp
    assign hit_vec[gi] = valid_reg[idx][gi] && (tag_reg[idx][gi] == tag);
  end

  logic          hit_any;
  logic [WW-1:0] hit_way, victim_way;
  logic [31:0]   hit_data;
  assign hit_any = (|hit_vec) && !flush_eff;

  always_comb begin
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WW'(w);
    for (int w = 0; w < WAYS; w++)
      if (age_reg[idx][w] == WW'(WAYS - 1)) victim_way = WW'(w);
    // Lowest-index invalid way overrides the LRU choice.
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_reg[idx][w]) victim_way = WW'(w);
    hit_data = data_reg[idx][hit_way][word_sel];
  end

  logic req_wr, req_rd, rd_hit, rd_miss, fill_done, write_hit;
  assign req_wr    = mem_w_en_in;
  assign req_rd    = mem_r_en_in && !mem_w_en_in;
  assign rd_hit    = (state_reg == S_IDLE) && req_rd && hit_any;
  assign rd_miss   = (state_reg == S_IDLE) && req_rd && !hit_any;
  assign fill_done = (state_reg == S_RFILL) && sram_ready_in;
  assign write_hit = (state_reg == S_WRITE) && sram_ready_in && hit_any;

  logic          touch_en;
  logic [WW-1:0] touch_way;
  assign touch_en  = rd_hit || fill_done || write_hit;
  assign touch_way = fill_done ? victim_way : hit_way;

  always_comb begin
    ready_out     = 1'b0;
    read_data_out = '0;
    case (state_reg)
      S_IDLE: begin
        ready_out = !req_wr && !rd_miss;
        if (rd_hit) read_data_out = hit_data;
      end
      S_RFILL: begin
        ready_out = sram_ready_in;
        if (sram_ready_in)
          read_data_out = word_sel ? sram_read_data_in[63:32] : sram_read_data_in[31:0];
      end
      S_WRITE: ready_out = sram_ready_in;
      default: ready_out = 1'b0;
    endcase
  end

  assign sram_addr_out       = (state_reg == S_WRITE) ? addr_full : (addr_full & ~32'd1);
  assign sram_write_data_out = write_data_in;
  assign sram_r_en_out       = sram_r_en_reg;
  assign sram_w_en_out       = sram_w_en_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      sram_r_en_reg  <= 1'b0;
      sram_w_en_reg  <= 1'b0;
      flush_pend_reg <= 1'b0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w] <= 1'b0;
          age_reg[s][w]   <= WW'(w);
        end
    end else begin
      if (flush_in && state_reg != S_IDLE) flush_pend_reg <= 1'b1;
      else if (state_reg == S_IDLE)        flush_pend_reg <= 1'b0;
      if (flush_eff)
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) valid_reg[s][w] <= 1'b0;
      if (fill_done) valid_reg[idx][victim_way] <= 1'b1;
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++)
          if (age_reg[idx][w] < age_reg[idx][touch_way])
            age_reg[idx][w] <= age_reg[idx][w] + 1'b1;
        age_reg[idx][touch_way] <= '0;
      end
      case (state_reg)
        S_IDLE: begin
          if (req_wr) begin
            state_reg     <= S_WRITE;
            sram_w_en_reg <= 1'b1;
          end else if (rd_miss) begin
            state_reg     <= S_RFILL;
            sram_r_en_reg <= 1'b1;
          end
        end
        S_RFILL: if (sram_ready_in) begin
          state_reg     <= S_IDLE;
          sram_r_en_reg <= 1'b0;
        end
        S_WRITE: if (sram_ready_in) begin
          state_reg     <= S_IDLE;
          sram_w_en_reg <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_reg[idx][victim_way]     <= tag;
      data_reg[idx][victim_way][0] <= sram_read_data_in[31:0];
      data_reg[idx][victim_way][1] <= sram_read_data_in[63:32];
    end
    if (write_hit) data_reg[idx][hit_way][word_sel] <= write_data_in;
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (rd_hit)  hit_cnt_reg  <= hit_cnt_reg + 32'd1;
      if (rd_miss) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end
  assign hit_count_out  = hit_cnt_reg;
  assign miss_count_out = miss_cnt_reg;
`endif
endmodule
